// File: rtl/pipe_ind_serializer_pkg.sv
// Shared types and constants for the indication-message serializer.
package pipe_ind_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam int NBEATS     = 4;
    localparam int CNT_W      = 2;
    localparam int HDR_NB_OFF = 16;
    localparam int HDR_SEQ_OFF = 24;

endpackage

// File: rtl/pipe_ind_serializer_chk.sv
// Simulation-only protocol checks for pipe_ind_serializer (enqueue legality, stall stability).
module pipe_ind_serializer_chk #(
    parameter int OUT_WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic                 enq_ena,
    input logic                 enq_rdy,
    input logic                 out_valid,
    input logic                 out_ready,
    input logic [OUT_WIDTH-1:0] out_data,
    input logic                 out_last
);

    a_enq_legal: assert property (@(posedge clk) disable iff (!rst_n)
        enq_ena |-> enq_rdy)
        else $error("illegal enqueue while not ready");

    a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)))
        else $error("output changed during stall");

endmodule

// File: rtl/pipe_ind_serializer.sv
// Serializes a header+payload indication message into 32-bit words with valid/ready/last.
// Optional macro PIPE_IND_SERIALIZER_SEQ_EN adds an 8-bit sequence number to the header word.
module pipe_ind_serializer
    import pipe_ind_serializer_pkg::*;
#(
    parameter int HDR_WIDTH  = 16,
    parameter int DATA_WIDTH = NBEATS * 32,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic                            in_enq__ENA,
    input  logic [HDR_WIDTH+DATA_WIDTH-1:0] in_enq_v,
    output logic                            in_enq__RDY,
    output logic                            out_valid,
    output logic [OUT_WIDTH-1:0]            out_data,
    output logic                            out_last,
    input  logic                            out_ready,
    output logic                            busy
);

    localparam int NBEATS_L = DATA_WIDTH / OUT_WIDTH;
    localparam int CNT_W_L  = (NBEATS_L > 1) ? $clog2(NBEATS_L) : 1;
    localparam logic [CNT_W_L-1:0] LAST_BEAT = CNT_W_L'(NBEATS_L - 1);
    localparam logic [15:0] NBEATS_W = 16'(NBEATS_L);

    state_e                  state_r;
    logic [CNT_W_L-1:0]      cnt_r;
    logic [CNT_W_L-1:0]      cnt_nxt_s;
    logic [DATA_WIDTH-1:0]   buf_r;
    logic [OUT_WIDTH-1:0]    hdr_word_s;
    logic [OUT_WIDTH-1:0]    beat_word_s;
    logic                    last_beat_s;
    logic                    hs_s;
    logic                    acc_s;
`ifdef PIPE_IND_SERIALIZER_SEQ_EN
    logic [7:0]              seq_r;
    logic [7:0]              seq_hdr_s;
`endif

    assign last_beat_s = (state_r == ST_DATA) && (cnt_r == LAST_BEAT);
    assign hs_s        = out_valid && out_ready;
    assign acc_s       = in_enq__ENA && in_enq__RDY;
    assign cnt_nxt_s   = cnt_r + {{(CNT_W_L-1){1'b0}}, 1'b1};
    assign busy        = (state_r != ST_IDLE);

    // Ready: free when idle, or when the last beat is leaving this very cycle.
    always_comb begin
        in_enq__RDY = 1'b0;
        case (state_r)
            ST_IDLE: in_enq__RDY = 1'b1;
            ST_DATA: in_enq__RDY = last_beat_s && out_ready;
            default: in_enq__RDY = 1'b0;
        endcase
    end

    // Header word and next data beat selection.
    always_comb begin
        hdr_word_s = '0;
        hdr_word_s[HDR_WIDTH-1:0] = in_enq_v[HDR_WIDTH+DATA_WIDTH-1 -: HDR_WIDTH];
`ifdef PIPE_IND_SERIALIZER_SEQ_EN
        // A message accepted during DATA starts after the current one completes, so it gets the next number.
        seq_hdr_s = (state_r == ST_DATA) ? (seq_r + 8'd1) : seq_r;
        hdr_word_s[HDR_NB_OFF +: 8]  = NBEATS_W[7:0];
        hdr_word_s[HDR_SEQ_OFF +: 8] = seq_hdr_s;
`else
        hdr_word_s[HDR_NB_OFF +: 16] = NBEATS_W;
`endif
        beat_word_s = buf_r[int'(cnt_nxt_s) * OUT_WIDTH +: OUT_WIDTH];
    end

    // FSM, beat counter, message buffer and registered output word.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            buf_r     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
`ifdef PIPE_IND_SERIALIZER_SEQ_EN
            seq_r     <= 8'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                end
                ST_HDR: begin
                    if (hs_s) begin
                        state_r  <= ST_DATA;
                        cnt_r    <= '0;
                        out_data <= buf_r[OUT_WIDTH-1:0];
                        out_last <= (NBEATS_L == 1);
                    end
                end
                ST_DATA: begin
                    if (hs_s) begin
                        if (cnt_r == LAST_BEAT) begin
`ifdef PIPE_IND_SERIALIZER_SEQ_EN
                            seq_r <= seq_r + 8'd1;
`endif
                            state_r   <= ST_IDLE;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            cnt_r    <= cnt_nxt_s;
                            out_data <= beat_word_s;
                            out_last <= (cnt_nxt_s == LAST_BEAT);
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_last  <= 1'b0;
                end
            endcase
            // Acceptance overrides the IDLE fallback above, giving back-to-back headers with no bubble.
            if (acc_s) begin
                state_r   <= ST_HDR;
                cnt_r     <= '0;
                buf_r     <= in_enq_v[DATA_WIDTH-1:0];
                out_valid <= 1'b1;
                out_data  <= hdr_word_s;
                out_last  <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    pipe_ind_serializer_chk #(.OUT_WIDTH(OUT_WIDTH)) u_chk (
        .clk       (CLK),
        .rst_n     (nRST),
        .enq_ena   (in_enq__ENA),
        .enq_rdy   (in_enq__RDY),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );
`endif

endmodule
